// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared types and default sizes for the packet router slice.
//   - state_t   : router FSM state encoding (7 states, 3 bits)
//   - *_DEF     : default widths/limits used as parameter defaults
//   - idx_width : width of a port index for a given port count
// -----------------------------------------------------------------------------
package sw_pkg;

    localparam int W_WIDTH_DEF   = 8;
    localparam int NUM_PORTS_DEF = 4;
    localparam int MAX_LEN_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ADDR_WAIT   = 3'd1,
        PORT_BUSY   = 3'd2,
        LEN_LOAD    = 3'd3,
        DATA_LOAD   = 3'd4,
        PARITY_LOAD = 3'd5,
        DROP        = 3'd6
    } state_t;

    // A single-port build still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_pkt_router_if.sv
// -----------------------------------------------------------------------------
// sw_pkt_router_if
// Byte-stream input, port configuration and per-port write bus of the router.
//   sw_en/data_in/in_ready : upstream byte handshake
//   port_addr/port_busy    : per-port address table and FIFO-full flags
//   wr_en/data_out         : registered one-hot write to the output FIFOs
//   pkt_drop/parity_err    : single-cycle status pulses
// Modports: master = upstream/environment side, slave = router side.
// -----------------------------------------------------------------------------
interface sw_pkt_router_if
    import sw_pkg::*;
#(
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int NUM_PORTS = NUM_PORTS_DEF
);

    logic                           sw_en;
    logic [W_WIDTH-1:0]             data_in;
    logic                           in_ready;
    logic [NUM_PORTS*W_WIDTH-1:0]   port_addr;
    logic [NUM_PORTS-1:0]           port_busy;
    logic [NUM_PORTS-1:0]           wr_en;
    logic [W_WIDTH-1:0]             data_out;
    logic                           pkt_drop;
    logic                           parity_err;

    modport master (
        output sw_en, data_in, port_addr, port_busy,
        input  in_ready, wr_en, data_out, pkt_drop, parity_err
    );

    modport slave (
        input  sw_en, data_in, port_addr, port_busy,
        output in_ready, wr_en, data_out, pkt_drop, parity_err
    );

endinterface

// File: rtl/sw_addr_match.sv
// -----------------------------------------------------------------------------
// sw_addr_match
// Combinational priority compare of a header byte against the port table.
//   data      in  : candidate header byte
//   port_addr in  : address of port i in [i*W_WIDTH +: W_WIDTH]
//   hit       out : at least one port matches
//   idx       out : lowest matching port index (0 when no hit)
// -----------------------------------------------------------------------------
module sw_addr_match
    import sw_pkg::*;
#(
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int IDX_W     = idx_width(NUM_PORTS_DEF)
) (
    input  logic [W_WIDTH-1:0]           data,
    input  logic [NUM_PORTS*W_WIDTH-1:0] port_addr,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx
);

    logic [NUM_PORTS-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cmp
            assign match[gi] = (data == port_addr[gi*W_WIDTH +: W_WIDTH]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit = |match;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sw_pkt_router.sv
// -----------------------------------------------------------------------------
// sw_pkt_router
// Frames an upstream byte stream into packets (header, length, payload,
// parity) and forwards each whole packet to the output FIFO whose address
// matches the header. Unknown or oversize packets are dropped, port_busy
// back-pressures upstream, and loss of sw_en mid-packet aborts the packet.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sw_pkt_router_if.slave (byte input, port table, FIFO writes, pulses)
// Build option: define SW_PARITY_CHECK_EN to compare the running XOR with the
// received parity byte and pulse parity_err alongside the parity write.
// -----------------------------------------------------------------------------
module sw_pkt_router
    import sw_pkg::*;
#(
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int MAX_LEN   = MAX_LEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    sw_pkt_router_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       tgt_q, tgt_d;
    logic [W_WIDTH-1:0]     count_q, count_d;
    logic [W_WIDTH-1:0]     hdr_q, hdr_d;
    logic [NUM_PORTS-1:0]   wr_en_q, wr_en_d;
    logic [W_WIDTH-1:0]     data_out_q, data_out_d;
    logic                   pkt_drop_q, pkt_drop_d;
`ifdef SW_PARITY_CHECK_EN
    logic [W_WIDTH-1:0]     parity_q, parity_d;
    logic                   parity_err_q, parity_err_d;
`endif

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   tgt_free;
    logic                   ready;

    sw_addr_match #(
        .W_WIDTH   (W_WIDTH),
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_addr_match (
        .data      (bus.data_in),
        .port_addr (bus.port_addr),
        .hit       (hit),
        .idx       (hit_idx)
    );

    assign tgt_free = !bus.port_busy[tgt_q];

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        count_d    = count_q;
        hdr_d      = hdr_q;
        wr_en_d    = '0;
        data_out_d = data_out_q;
        pkt_drop_d = 1'b0;
        ready      = 1'b0;
`ifdef SW_PARITY_CHECK_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            // Ready is advertised here so upstream opens the envelope, but
            // the header is only taken once ADDR_WAIT is reached.
            IDLE: begin
                ready = 1'b1;
                if (bus.sw_en) begin
                    state_d = ADDR_WAIT;
                end
            end

            ADDR_WAIT: begin
                ready = 1'b1;
                if (!bus.sw_en) begin
                    state_d = IDLE;
                end else if (!hit) begin
                    state_d    = DROP;
                    pkt_drop_d = 1'b1;
                end else begin
                    tgt_d = hit_idx;
`ifdef SW_PARITY_CHECK_EN
                    parity_d = bus.data_in;
`endif
                    if (bus.port_busy[hit_idx]) begin
                        hdr_d   = bus.data_in;
                        state_d = PORT_BUSY;
                    end else begin
                        wr_en_d[hit_idx] = 1'b1;
                        data_out_d       = bus.data_in;
                        state_d          = LEN_LOAD;
                    end
                end
            end

            // Header is parked in hdr_q; no new byte is taken until it is out.
            PORT_BUSY: begin
                if (!bus.sw_en) begin
                    state_d    = IDLE;
                    pkt_drop_d = 1'b1;
                end else if (tgt_free) begin
                    wr_en_d[tgt_q] = 1'b1;
                    data_out_d     = hdr_q;
                    state_d        = LEN_LOAD;
                end
            end

            LEN_LOAD, DATA_LOAD, PARITY_LOAD: begin
                ready = tgt_free;
                if (!bus.sw_en) begin
                    state_d    = IDLE;
                    pkt_drop_d = 1'b1;
                end else if (tgt_free) begin
                    wr_en_d[tgt_q] = 1'b1;
                    data_out_d     = bus.data_in;
`ifdef SW_PARITY_CHECK_EN
                    parity_d = parity_q ^ bus.data_in;
`endif
                    if (state_q == LEN_LOAD) begin
                        // The oversize length byte is still written so the
                        // consumer sees where the packet was cut off.
                        if (bus.data_in > W_WIDTH'(MAX_LEN)) begin
                            state_d    = DROP;
                            pkt_drop_d = 1'b1;
                        end else if (bus.data_in == '0) begin
                            state_d = PARITY_LOAD;
                        end else begin
                            count_d = bus.data_in;
                            state_d = DATA_LOAD;
                        end
                    end else if (state_q == DATA_LOAD) begin
                        count_d = count_q - W_WIDTH'(1);
                        if (count_q == W_WIDTH'(1)) begin
                            state_d = PARITY_LOAD;
                        end
                    end else begin
`ifdef SW_PARITY_CHECK_EN
                        parity_err_d = (parity_q != bus.data_in);
`endif
                        state_d = ADDR_WAIT;
                    end
                end
            end

            DROP: begin
                ready = 1'b1;
                if (!bus.sw_en) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            count_q    <= '0;
            hdr_q      <= '0;
            wr_en_q    <= '0;
            data_out_q <= '0;
            pkt_drop_q <= 1'b0;
`ifdef SW_PARITY_CHECK_EN
            parity_q     <= '0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            count_q    <= count_d;
            hdr_q      <= hdr_d;
            wr_en_q    <= wr_en_d;
            data_out_q <= data_out_d;
            pkt_drop_q <= pkt_drop_d;
`ifdef SW_PARITY_CHECK_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.in_ready = ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.data_out = data_out_q;
    assign bus.pkt_drop = pkt_drop_q;
`ifdef SW_PARITY_CHECK_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sw_pkt_router.sv
// -----------------------------------------------------------------------------
// tb_sw_pkt_router
// Directed packets into sw_pkt_router. A packet-position model predicts every
// cycle's outputs; a log of FIFO writes is also compared against the literal
// packet bytes of each test.
// -----------------------------------------------------------------------------
module tb_sw_pkt_router;
    import sw_pkg::*;

    localparam int W    = 8;
    localparam int NP   = 4;
    localparam int MAXL = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sw_pkt_router_if #(.W_WIDTH(W), .NUM_PORTS(NP)) bus();

    sw_pkt_router #(.W_WIDTH(W), .NUM_PORTS(NP), .MAX_LEN(MAXL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model: tracks byte position inside the packet ----------
    bit          m_open, m_drop, m_hpend;
    int          m_pos, m_len, m_tgt;
    logic [7:0]  m_xor, m_hdr;
    bit [NP-1:0] e_wr;
    logic [7:0]  e_data;
    bit          e_dchk, e_drop, e_perr;

    function automatic int lookup(input logic [7:0] d);
        for (int i = 0; i < NP; i++) begin
            if (bus.port_addr[i*W +: W] == d) return i;
        end
        return -1;
    endfunction

    function automatic bit model_ready();
        if (!m_open || m_drop || m_pos == 0) return 1'b1;
        if (m_hpend) return 1'b0;
        return !bus.port_busy[m_tgt];
    endfunction

    task automatic emit(input logic [7:0] d);
        e_wr       = '0;
        e_wr[m_tgt] = 1'b1;
        e_data     = d;
        e_dchk     = 1'b1;
    endtask

    task automatic model_step();
        logic [7:0] d;
        int t;
        d      = bus.data_in;
        e_wr   = '0;
        e_drop = 1'b0;
        e_perr = 1'b0;
        e_dchk = 1'b0;
        if (rst) begin
            m_open = 0; m_drop = 0; m_hpend = 0; m_pos = 0;
            e_data = 8'h00; e_dchk = 1'b1;
        end else if (!m_open) begin
            if (bus.sw_en) begin m_open = 1; m_pos = 0; end
        end else if (m_drop) begin
            if (!bus.sw_en) begin m_open = 0; m_drop = 0; end
        end else if (!bus.sw_en) begin
            e_drop = (m_pos > 0);
            m_open = 0; m_pos = 0; m_hpend = 0;
        end else if (m_pos == 0) begin
            t = lookup(d);
            if (t < 0) begin
                m_drop = 1; e_drop = 1'b1;
            end else begin
                m_tgt = t; m_xor = d; m_pos = 1;
                if (bus.port_busy[t]) begin m_hpend = 1; m_hdr = d; end
                else emit(d);
            end
        end else if (m_hpend) begin
            if (!bus.port_busy[m_tgt]) begin emit(m_hdr); m_hpend = 0; end
        end else if (!bus.port_busy[m_tgt]) begin
            emit(d);
            if (m_pos == 1) begin
                m_len = int'(d);
                if (m_len > MAXL) begin m_drop = 1; e_drop = 1'b1; end
                else begin m_pos = 2; m_xor ^= d; end
            end else if (m_pos < m_len + 2) begin
                m_xor ^= d; m_pos++;
            end else begin
`ifdef SW_PARITY_CHECK_EN
                e_perr = (d != m_xor);
`endif
                m_pos = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process + write log ----------------------------
    logic [15:0] wr_log[$];
    int n_drop = 0, n_perr = 0, n_stall = 0;

    initial forever begin
        @(negedge clk);
        check("wr_en", 32'(bus.wr_en), 32'(e_wr));
        if (e_dchk) check("data_out", 32'(bus.data_out), 32'(e_data));
        check("pkt_drop", 32'(bus.pkt_drop), 32'(e_drop));
        check("parity_err", 32'(bus.parity_err), 32'(e_perr));
        check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
        if (bus.wr_en != '0) begin
            int p = 0;
            for (int i = 0; i < NP; i++) if (bus.wr_en[i]) p = i;
            wr_log.push_back({8'(p), bus.data_out});
            $display("write port %0d data %02h drop %0b perr %0b", p, bus.data_out, bus.pkt_drop, bus.parity_err);
        end
        if (bus.pkt_drop) n_drop++;
        if (bus.parity_err) n_perr++;
        if (bus.sw_en && !bus.in_ready) n_stall++;
    end

    // ---------------- driver ------------------------------------------------
    logic [7:0] pkt[$];
    int mark, d0, p0, s0;

    task automatic idle_cycle();
        bus.sw_en = 1'b0;
        @(posedge clk); #2;
    endtask

    // First sw_en cycle out of IDLE does not consume the byte.
    task automatic wake(input logic [7:0] h);
        bus.sw_en = 1'b1; bus.data_in = h;
        @(posedge clk); #2;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n;
        bit rdy;
        bus.sw_en = 1'b1; bus.data_in = d; n = 0;
        do begin
            @(negedge clk); rdy = bus.in_ready;
            @(posedge clk); #2; n++;
        end while (!rdy && n < 40);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for byte %02h", d);
        end
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(pkt[i]);
    endtask

    task automatic begin_test();
        mark = wr_log.size(); d0 = n_drop; p0 = n_perr; s0 = n_stall;
    endtask

    task automatic check_count(input string name, input int n);
        check(name, 32'(wr_log.size() - mark), 32'(n));
    endtask

    // New log entries [off, off+n) must be pkt[off..] written to port.
    task automatic check_seg(input string name, input int port, input int off, input int n);
        for (int i = 0; i < n; i++) begin
            if (mark + off + i < wr_log.size())
                check(name, 32'(wr_log[mark+off+i]), 32'({8'(port), pkt[off+i]}));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.sw_en = 1'b0; bus.data_in = 8'h00; bus.port_busy = '0;
        bus.port_addr = {8'h33, 8'h22, 8'h11, 8'h00};
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_wr_en", 32'(bus.wr_en), 32'h0);
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_pkt_drop", 32'(bus.pkt_drop), 32'h0);
        check("rst_parity_err", 32'(bus.parity_err), 32'h0);
        @(posedge clk); #2;

        // Good packet to port 2; parity 22^03^AA^BB^CC = FC
        begin_test();
        pkt = '{8'h22, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hFC};
        wake(8'h22); send_range(0, 5); idle_cycle(); idle_cycle();
        check_count("good_cnt", 6); check_seg("good", 2, 0, 6);
        check("good_drop", 32'(n_drop - d0), 0);
        check("good_perr", 32'(n_perr - p0), 0);

        // Unknown header: dropped, nothing written
        begin_test();
        pkt = '{8'h55, 8'h01, 8'h02};
        wake(8'h55); send_range(0, 2); idle_cycle(); idle_cycle();
        check_count("unk_cnt", 0);
        check("unk_drop", 32'(n_drop - d0), 1);

        // Next packet routes normally: 00^01^5A = 5B
        begin_test();
        pkt = '{8'h00, 8'h01, 8'h5A, 8'h5B};
        wake(8'h00); send_range(0, 3); idle_cycle(); idle_cycle();
        check_count("after_unk_cnt", 4); check_seg("after_unk", 0, 0, 4);

        // Port 1 busy at header, released later: 11^02^01^02 = 10
        bus.port_busy[1] = 1'b1;
        pkt = '{8'h11, 8'h02, 8'h01, 8'h02, 8'h10};
        wake(8'h11);
        begin_test();
        send_byte(pkt[0]);
        fork
            send_range(1, 4);
            begin repeat (4) @(posedge clk); #2 bus.port_busy[1] = 1'b0; end
        join
        idle_cycle(); idle_cycle();
        check("busy_stall", 32'(n_stall - s0), 5);
        check_count("busy_cnt", 5); check_seg("busy", 1, 0, 5);

        // Mid-packet stall on port 3: 33^02^44^55 = 20
        begin_test();
        pkt = '{8'h33, 8'h02, 8'h44, 8'h55, 8'h20};
        wake(8'h33); send_range(0, 1);
        bus.port_busy[3] = 1'b1;
        fork
            send_range(2, 4);
            begin repeat (2) @(posedge clk); #2 bus.port_busy[3] = 1'b0; end
        join
        idle_cycle(); idle_cycle();
        check("stall_cycles", 32'(n_stall - s0), 2);
        check_count("stall_cnt", 5); check_seg("stall", 3, 0, 5);

        // Oversize length 40: header + length written, then dropped
        begin_test();
        pkt = '{8'h22, 8'd40, 8'h01, 8'h02, 8'h03};
        wake(8'h22); send_range(0, 4); idle_cycle(); idle_cycle();
        check_count("ovr_cnt", 2); check_seg("ovr", 2, 0, 2);
        check("ovr_drop", 32'(n_drop - d0), 1);

        // Abort after 2 of 4 payload bytes
        begin_test();
        pkt = '{8'h33, 8'h04, 8'h01, 8'h02};
        wake(8'h33); send_range(0, 3); idle_cycle(); idle_cycle(); idle_cycle();
        check_count("abort_cnt", 4); check_seg("abort", 3, 0, 4);
        check("abort_drop", 32'(n_drop - d0), 1);

        // Zero length then two back-to-back packets, one envelope
        begin_test();
        pkt = '{8'h00, 8'h00, 8'h00,
                8'h11, 8'h01, 8'h77, 8'h67,
                8'h22, 8'h01, 8'h88, 8'hAB};
        wake(8'h00); send_range(0, 10); idle_cycle(); idle_cycle();
        check_count("b2b_cnt", 11);
        check_seg("b2b_p0", 0, 0, 3); check_seg("b2b_p1", 1, 3, 4); check_seg("b2b_p2", 2, 7, 4);
        check("b2b_drop", 32'(n_drop - d0), 0);

        // Corrupt parity: true 22^01^09 = 2A, sent 2B
        begin_test();
        pkt = '{8'h22, 8'h01, 8'h09, 8'h2B};
        wake(8'h22); send_range(0, 3); idle_cycle(); idle_cycle();
        check_count("par_cnt", 4); check_seg("par", 2, 0, 4);
`ifdef SW_PARITY_CHECK_EN
        check("par_err_pulses", 32'(n_perr - p0), 1);
`else
        check("par_err_pulses", 32'(n_perr - p0), 0);
`endif

        // Two ports share 22: lowest index wins. 22^01^05 = 26
        bus.port_addr[3*W +: W] = 8'h22;
        begin_test();
        pkt = '{8'h22, 8'h01, 8'h05, 8'h26};
        wake(8'h22); send_range(0, 3); idle_cycle(); idle_cycle();
        check_count("multi_cnt", 4); check_seg("multi", 2, 0, 4);
        bus.port_addr[3*W +: W] = 8'h33;

        // Reset mid-packet: no writes after it, no drop pulse
        begin_test();
        pkt = '{8'h11, 8'h05, 8'h01};
        wake(8'h11); send_range(0, 2);
        rst = 1'b1; @(posedge clk); #2;
        rst = 1'b0; idle_cycle(); idle_cycle();
        check_count("rst_mid_cnt", 3); check_seg("rst_mid", 1, 0, 3);
        check("rst_mid_drop", 32'(n_drop - d0), 0);

        // Recovery after reset
        begin_test();
        pkt = '{8'h00, 8'h01, 8'h5A, 8'h5B};
        wake(8'h00); send_range(0, 3); idle_cycle(); idle_cycle();
        check_count("recover_cnt", 4); check_seg("recover", 0, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
